// File: rtl/ctrl_pipe_gen_pkg.sv
// Shared constants for the control pipeline: condition codes, flag bit
// positions and the multicycle FSM state encoding.
package ctrl_pipe_gen_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int FLAG_V          = 0;
  localparam int FLAG_C          = 1;
  localparam int FLAG_Z          = 2;
  localparam int FLAG_N          = 3;
  localparam int FLAG_STICKY_LSB = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mc_state_e;

endpackage

// File: rtl/ctrl_pipe_gen_cond_eval.sv
// ARM-style condition evaluation: decides whether an instruction's
// condition field passes against the current N,Z,C,V flags.
module cond_eval
  import ctrl_pipe_gen_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/ctrl_pipe_gen_reg.sv
// Positive-edge register with synchronous clear (dominant) and load enable.
module ctrl_pipe_gen_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/ctrl_pipe_gen.sv
// Control-word pipeline from E onward: condition gating, multicycle E-stage
// hold with decode stall, branch flush, and the architectural flag register.
module ctrl_pipe_gen
  import ctrl_pipe_gen_pkg::*;
#(
  parameter int CTRL_W  = 16,
  parameter int GATE_W  = 4,
  parameter int FLAGS_W = 5,
  parameter int NSTAGES = 3,
  parameter int MC_LAT  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      validD,
  input  logic [CTRL_W-1:0]         ctrlD,
  input  logic [3:0]                condD,
  input  logic [1:0]                flagWrD,
  input  logic                      mcD,
  input  logic                      flushE,
  input  logic [FLAGS_W-1:0]        aluFlagsE,
  output logic [NSTAGES*CTRL_W-1:0] ctrlPipe,
  output logic [NSTAGES-1:0]        validPipe,
  output logic                      condExE,
  output logic [FLAGS_W-1:0]        flagsQ,
  output logic                      stallD
);

  localparam int CNT_W = $clog2(MC_LAT);
  localparam int E_W   = 1 + CTRL_W + 4 + 2 + 1;

  logic                valid_p0, mc_p0, cond_pass;
  logic [CTRL_W-1:0]   ctrl_p0, ctrl_gated_p0;
  logic [3:0]          cond_p0;
  logic [1:0]          flag_wr_p0;
  logic [E_W-1:0]      e_d, e_q;
  mc_state_e           state;
  logic [CNT_W-1:0]    cnt;
  logic                mc_final, squash, flag_upd;
  logic                valid_in_p1;
  logic [CTRL_W-1:0]   ctrl_in_p1;
  logic [FLAGS_W-1:0]  flags_nxt;
  logic [CTRL_W:0]     stg_q [1:NSTAGES-1];

  // ---- D -> E: hold while stalled, flush loads a bubble and drops decode ----
  assign e_d = {validD, ctrlD, condD, flagWrD, mcD};
  assign {valid_p0, ctrl_p0, cond_p0, flag_wr_p0, mc_p0} = e_q;

  ctrl_pipe_gen_reg #(.W(E_W)) u_reg_e (
    .clk (clk),
    .en  (!stallD),
    .clr (reset || flushE),
    .d   (e_d),
    .q   (e_q)
  );

  cond_eval u_cond (
    .cond  (cond_p0),
    .flags (flagsQ[3:0]),
    .pass  (cond_pass)
  );

  assign condExE  = valid_p0 && cond_pass;
  assign mc_final = (state == ST_BUSY) && (cnt == '0);
  assign stallD   = !flushE && mc_p0 && condExE && !mc_final;

  always_ff @(posedge clk) begin
    if (reset || flushE) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mc_p0 && condExE) begin
            state <= ST_BUSY;
            cnt   <= CNT_W'(MC_LAT - 2);
          end
        end
        ST_BUSY: begin
          if (cnt == '0) state <= ST_IDLE;
          else cnt <= cnt - CNT_W'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ctrl_gated_p0 = ctrl_p0;
    for (int i = 0; i < GATE_W; i++) ctrl_gated_p0[i] = ctrl_p0[i] & condExE;
  end

  // A flushed E instruction is squashed rather than forwarded.
  assign squash      = stallD || flushE;
  assign valid_in_p1 = valid_p0 && !squash;
  assign ctrl_in_p1  = squash ? '0 : ctrl_gated_p0;

  // ---- E -> stage 1 .. NSTAGES-1: unconditional shift ----
  for (genvar k = 1; k < NSTAGES; k++) begin : g_stage
    logic [CTRL_W:0] stg_d;
    if (k == 1) begin : g_first
      assign stg_d = {valid_in_p1, ctrl_in_p1};
    end else begin : g_rest
      assign stg_d = stg_q[k-1];
    end

    ctrl_pipe_gen_reg #(.W(CTRL_W + 1)) u_reg_s (
      .clk (clk),
      .en  (1'b1),
      .clr (reset),
      .d   (stg_d),
      .q   (stg_q[k])
    );

    assign ctrlPipe[k*CTRL_W +: CTRL_W] = stg_q[k][CTRL_W-1:0];
    assign validPipe[k]                 = stg_q[k][CTRL_W];
  end

  assign ctrlPipe[CTRL_W-1:0] = ctrl_gated_p0;
  assign validPipe[0]         = valid_p0;

  // ---- flag register: written only when the E op retires from E ----
  assign flag_upd = condExE && !stallD && !flushE;

  always_comb begin
    flags_nxt = flagsQ;
    if (flag_upd) begin
      if (flag_wr_p0[1]) begin
        flags_nxt[FLAG_N] = aluFlagsE[FLAG_N];
        flags_nxt[FLAG_Z] = aluFlagsE[FLAG_Z];
      end
      if (flag_wr_p0[0]) begin
        flags_nxt[FLAG_C] = aluFlagsE[FLAG_C];
        flags_nxt[FLAG_V] = aluFlagsE[FLAG_V];
        for (int i = FLAG_STICKY_LSB; i < FLAGS_W; i++) flags_nxt[i] = aluFlagsE[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) flagsQ <= '0;
    else flagsQ <= flags_nxt;
  end

endmodule

// File: tb/tb_ctrl_pipe_gen.sv
// Scoreboard bench for ctrl_pipe_gen: expected last-stage control words are
// queued at issue and popped by a monitor; flags/stall checked inline.
module tb_ctrl_pipe_gen;
  import ctrl_pipe_gen_pkg::*;

  logic        clk = 1'b0;
  logic        reset, validD, mcD, flushE, condExE, stallD;
  logic [15:0] ctrlD;
  logic [3:0]  condD;
  logic [1:0]  flagWrD;
  logic [4:0]  aluFlagsE, flagsQ;
  logic [47:0] ctrlPipe;
  logic [2:0]  validPipe;

  int          n_total = 0;
  int          n_pass  = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mon_exp;
  logic [15:0] tbl;
  logic [15:0] c;

  always #5 clk = ~clk;

  ctrl_pipe_gen #(
    .CTRL_W(16), .GATE_W(4), .FLAGS_W(5), .NSTAGES(3), .MC_LAT(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .validD    (validD),
    .ctrlD     (ctrlD),
    .condD     (condD),
    .flagWrD   (flagWrD),
    .mcD       (mcD),
    .flushE    (flushE),
    .aluFlagsE (aluFlagsE),
    .ctrlPipe  (ctrlPipe),
    .validPipe (validPipe),
    .condExE   (condExE),
    .flagsQ    (flagsQ),
    .stallD    (stallD)
  );

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] ctl, input logic [3:0] cd,
                       input logic [1:0] fw, input logic m);
    validD  = 1'b1;
    ctrlD   = ctl;
    condD   = cd;
    flagWrD = fw;
    mcD     = m;
    tick();
    validD  = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset && validPipe[2]) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL w_unexpected: got %0h expected none", ctrlPipe[47:32]);
      end else begin
        mon_exp = exp_q.pop_front();
        check("w_ctrl", {32'h0, ctrlPipe[47:32]}, {32'h0, mon_exp});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; validD = 1'b0; ctrlD = '0; condD = '0; flagWrD = '0;
    mcD = 1'b0; flushE = 1'b0; aluFlagsE = '0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_valid", validPipe, 0);
    check("rst_ctrl", ctrlPipe, 0);
    check("rst_flags", flagsQ, 0);
    check("rst_stall", stallD, 0);
    check("rst_condex", condExE, 0);
    tick();
    reset = 1'b0;

    // ADD, always: flags written, control reaches W after NSTAGES cycles
    issue(16'h1234, COND_AL, 2'b11, 1'b0);
    aluFlagsE = 5'b00110;
    @(negedge clk);
    check("add_condex", condExE, 1);
    check("add_stall", stallD, 0);
    exp_q.push_back(16'h1234);
    tick();
    @(negedge clk);
    check("add_flags", flagsQ, 5'b00110);
    tick();
    @(negedge clk);
    check("add_w_valid", validPipe[2], 1);
    check("add_w_ctrl", ctrlPipe[47:32], 16'h1234);

    // EQ passes with Z=1, NE fails and gets gated
    issue(16'h00FF, COND_EQ, 2'b00, 1'b0);
    @(negedge clk);
    check("eq_condex", condExE, 1);
    exp_q.push_back(16'h00FF);
    tick();
    @(negedge clk);
    check("eq_s1_ctrl", ctrlPipe[31:16], 16'h00FF);
    issue(16'h00FF, COND_NE, 2'b11, 1'b0);
    aluFlagsE = 5'b11111;
    @(negedge clk);
    check("ne_condex", condExE, 0);
    exp_q.push_back(16'h00F0);
    tick();
    @(negedge clk);
    check("ne_s1_ctrl", ctrlPipe[31:16], 16'h00F0);
    check("ne_flags", flagsQ, 5'b00110);

    // partial flag-write mask
    issue(16'h0A01, COND_AL, 2'b11, 1'b0);
    aluFlagsE = 5'b00000;
    @(negedge clk);
    exp_q.push_back(16'h0A01);
    tick();
    @(negedge clk);
    check("clr_flags", flagsQ, 5'b00000);
    issue(16'h0A02, COND_AL, 2'b10, 1'b0);
    aluFlagsE = 5'b11111;
    @(negedge clk);
    exp_q.push_back(16'h0A02);
    tick();
    @(negedge clk);
    check("nz_only_flags", flagsQ, 5'b01100);

    // multicycle op: 3 stall cycles, 3 bubbles, then advance; decode held
    issue(16'hBEEF, COND_AL, 2'b00, 1'b1);
    validD = 1'b1; ctrlD = 16'h5555; condD = COND_AL; flagWrD = 2'b00; mcD = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("mul_stall_%0d", k), stallD, (k < 3));
      if (k > 0) check($sformatf("mul_bubble_%0d", k), validPipe[1], 0);
      if (k == 0) exp_q.push_back(16'hBEEF);
      tick();
    end
    validD = 1'b0;
    exp_q.push_back(16'h5555);
    @(negedge clk);
    check("mul_s1_valid", validPipe[1], 1);
    check("mul_s1_ctrl", ctrlPipe[31:16], 16'hBEEF);
    check("held_d_in_e", ctrlPipe[15:0], 16'h5555);
    check("held_d_valid", validPipe[0], 1);
    check("mul_done_stall", stallD, 0);
    tick();

    // flush during the 2nd BUSY cycle, with a decode instruction dropped
    issue(16'hC0DE, COND_AL, 2'b11, 1'b1);
    aluFlagsE = 5'b11111;
    @(negedge clk);
    check("fl_entry_stall", stallD, 1);
    tick();
    @(negedge clk);
    check("fl_busy1_stall", stallD, 1);
    tick();
    flushE = 1'b1;
    validD = 1'b1; ctrlD = 16'hDEAD; condD = COND_AL; mcD = 1'b0;
    @(negedge clk);
    check("fl_stall_drop", stallD, 0);
    tick();
    flushE = 1'b0;
    validD = 1'b0;
    @(negedge clk);
    check("fl_e_bubble", validPipe[0], 0);
    check("fl_s1_bubble", validPipe[1], 0);
    check("fl_flags", flagsQ, 5'b01100);
    check("fl_stall_after", stallD, 0);
    issue(16'h7777, COND_AL, 2'b00, 1'b0);
    @(negedge clk);
    check("post_fl_stall", stallD, 0);
    check("post_fl_condex", condExE, 1);
    exp_q.push_back(16'h7777);
    repeat (3) tick();

    // reset in the middle of BUSY aborts the op
    issue(16'h9999, COND_AL, 2'b11, 1'b1);
    aluFlagsE = 5'b00011;
    tick();
    @(negedge clk);
    check("rb_busy_stall", stallD, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rb_valid", validPipe, 0);
    check("rb_ctrl", ctrlPipe, 0);
    check("rb_flags", flagsQ, 0);
    check("rb_stall", stallD, 0);
    check("rb_condex", condExE, 0);
    issue(16'h4242, COND_AL, 2'b11, 1'b0);
    aluFlagsE = 5'b10101;
    @(negedge clk);
    check("rb_next_condex", condExE, 1);
    check("rb_next_stall", stallD, 0);
    exp_q.push_back(16'h4242);
    tick();
    @(negedge clk);
    check("rb_next_flags", flagsQ, 5'b10101);

    // multicycle op with failing condition: no stall, gated, flags kept
    issue(16'h0F0F, COND_NE, 2'b11, 1'b1);
    aluFlagsE = 5'b11111;
    @(negedge clk);
    check("mcf_condex", condExE, 0);
    check("mcf_stall", stallD, 0);
    exp_q.push_back(16'h0F00);
    tick();
    @(negedge clk);
    check("mcf_s1_valid", validPipe[1], 1);
    check("mcf_s1_ctrl", ctrlPipe[31:16], 16'h0F00);
    check("mcf_flags", flagsQ, 5'b10101);

    // full condition table, back-to-back, against N=0 Z=1 C=0 V=1
    tbl = 16'h6A69;
    for (int i = 0; i < 16; i++) begin
      c = 16'hA00F | 16'(i << 4);
      validD = 1'b1; ctrlD = c; condD = 4'(i); flagWrD = 2'b00; mcD = 1'b0;
      tick();
      @(negedge clk);
      check($sformatf("cond_%0d", i), condExE, tbl[i]);
      exp_q.push_back(tbl[i] ? c : (c & 16'hFFF0));
    end
    validD = 1'b0;

    repeat (5) tick();
    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe_gen.md
CTRL_PIPE_GEN -- requirements
Module: ctrl_pipe_gen

Interface
REQ-001 Parameter CTRL_W, default 16, width of the per-instruction control word carried down the pipe.
REQ-002 Parameter GATE_W, default 4, count of low control bits (write enables) gated by the condition result; SHALL satisfy 1 <= GATE_W <= CTRL_W.
REQ-003 Parameter FLAGS_W, default 5, flag register width; bits [3:0] = V,C,Z,N (bit0 = V), bits above 3 = sticky/saturation.
REQ-004 Parameter NSTAGES, default 3, number of stages after decode (E, M, W, ...); SHALL be >= 2.
REQ-005 Parameter MC_LAT, default 4, E-stage residency in cycles of a multicycle op; SHALL be >= 2.
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 validD  in  1  decode stage holds a real instruction.
REQ-009 ctrlD  in  CTRL_W  decoded control word.
REQ-010 condD  in  4  condition field, Instr[31:28].
REQ-011 flagWrD  in  2  [1] = update N,Z; [0] = update C,V and bits above 3.
REQ-012 mcD  in  1  instruction is multicycle (MUL/DIV class).
REQ-013 flushE  in  1  insert bubble into E (branch mispredict).
REQ-014 aluFlagsE  in  FLAGS_W  flags produced by the ALU for the E instruction.
REQ-015 ctrlPipe  out  NSTAGES*CTRL_W  gated control word per stage; slice 0 = E.
REQ-016 validPipe  out  NSTAGES  per-stage valid; bit 0 = E.
REQ-017 condExE  out  1  E instruction valid and condition passed.
REQ-018 flagsQ  out  FLAGS_W  architectural flag register.
REQ-019 stallD  out  1  decode must hold its instruction this cycle.

Function
REQ-020 Condition evaluation uses the full ARM table (EQ..LE) against flagsQ; 1110 always passes; 1111 never passes.
REQ-021 condExE SHALL be combinational from E-stage cond and flagsQ, ANDed with validPipe[0].
REQ-022 Low GATE_W bits of the E control word SHALL be ANDed with condExE when written into stage 1; upper bits pass ungated.
REQ-023 Stages 1..NSTAGES-1 SHALL shift unconditionally each cycle; the E to stage-1 transfer SHALL carry a bubble (valid 0, ctrl 0) while E is in a non-final multicycle cycle.
REQ-024 Single-cycle ops: D to E latency 1 cycle; E to W latency NSTAGES-1 cycles.
REQ-025 Multicycle FSM states: IDLE, BUSY. IDLE to BUSY when E holds a valid mcD op with condExE = 1; the counter loads MC_LAT-2.
REQ-026 In BUSY, the counter decrements each cycle; BUSY returns to IDLE on the cycle the counter is 0, and that cycle the op advances to stage 1.
REQ-027 A multicycle op whose condition fails SHALL NOT enter BUSY; it advances as a gated single-cycle op.
REQ-028 stallD SHALL be 1 in every cycle E holds an unfinished multicycle op (entry cycle included, final cycle excluded); while stallD = 1, E SHALL hold its contents.
REQ-029 flagsQ SHALL update only when E is valid, condExE = 1 and the op advances that cycle; update per flagWr mask using aluFlagsE.
REQ-030 flushE SHALL load a bubble into E, force the FSM to IDLE, clear the counter, drop stallD in the same cycle and suppress the E flag update; it has priority over stall.
REQ-031 Simultaneous flushE and validD: the flush wins and the decode instruction is dropped.

Reset
REQ-032 On reset: all ctrlPipe and validPipe bits 0, flagsQ 0, FSM IDLE, counter 0, stallD 0, condExE 0.
REQ-033 Reset during BUSY SHALL abort the op with no flag update.

Structure
REQ-034 Condition-code constants, the FLAGS_W bit-index constants and the FSM state enum SHALL live in the shared controller package.
REQ-035 Condition evaluation SHALL be a separate sub-module cond_eval (cond, flags -> pass).
REQ-036 Stage registers SHALL reuse the existing positive-edge register with enable and clear.

Verification
REQ-037 ADD with cond 1110, flagWr 11, aluFlagsE 5'b00110 -> flagsQ = 00110 after 1 cycle; ctrl reaches the last stage after NSTAGES cycles.
REQ-038 flagsQ Z = 1, EQ-conditional op with ctrl 0x00FF, GATE_W 4 -> stage-1 ctrl 0x00FF; with NE -> stage-1 ctrl 0x00F0 and flagsQ unchanged.
REQ-039 MUL with mcD 1, MC_LAT 4 -> stallD high 3 cycles, 3 bubbles in stage 1, op in stage 1 on the 4th cycle.
REQ-040 flushE asserted in the 2nd BUSY cycle -> stallD 0 in that cycle, E becomes a bubble, FSM IDLE, flags unchanged.
REQ-041 Reset pulsed mid-BUSY -> all outputs match REQ-032 on the next cycle; a following single-cycle op completes normally.
REQ-042 flagWr 10 with aluFlagsE 11111 from flagsQ 00000 -> flagsQ = 01100 (N and Z only).
